// File: rtl/printer_receiver.sv
// Printer-side responder for the POC parallel port: captures TR/PD into a
// small FIFO, drives RDY back, and drains characters at a fixed print rate.
module printer_receiver #(
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int ACK_CYCLES   = 2,
   parameter int PRINT_CYCLES = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_tr,
   input  logic [DATA_W-1:0]             i_pd,
   output logic                          o_rdy,
   output logic                          o_print_valid,
   output logic [DATA_W-1:0]             o_print_data,
   output logic                          o_busy,
   output logic [15:0]                   o_char_count,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int AW = $clog2(ACK_CYCLES + 1);
   localparam int CW = $clog2(PRINT_CYCLES + 1);
   localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES - 1);
   localparam logic [CW-1:0] PRN_LOAD = CW'(PRINT_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {HS_IDLE, HS_WAIT, HS_FULL} hs_e;
   typedef enum logic {P_IDLE, P_BUSY} pr_e;

   hs_e               hs_q, hs_d;
   pr_e               pr_q, pr_d;
   logic [AW-1:0]     ack_q, ack_d;
   logic [CW-1:0]     prn_q, prn_d;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_q, rd_q;
   logic [LW-1:0]     lvl_q, lvl_d;
   logic [DATA_W-1:0] char_q;
   logic              push, pop, done;

   assign push  = (hs_q == HS_IDLE) && i_tr;
   assign pop   = (pr_q == P_IDLE) && (lvl_q != '0);
   assign done  = (pr_q == P_BUSY) && (prn_q == '0);
   assign lvl_d = lvl_q + LW'(push) - LW'(pop);

   assign o_rdy        = (hs_q == HS_IDLE);
   assign o_fifo_level = lvl_q;

   // The full test uses the post-push/pop level so RDY never reopens
   // onto a FIFO that cannot take the next character.
   always_comb begin
      hs_d  = hs_q;
      ack_d = ack_q;
      unique case (hs_q)
         HS_IDLE: begin
            if (i_tr) begin
               hs_d  = HS_WAIT;
               ack_d = ACK_LOAD;
            end
         end
         HS_WAIT: begin
            if (ack_q != '0) begin
               ack_d = ack_q - AW'(1);
            end else if (lvl_d == FULL_LVL) begin
               hs_d = HS_FULL;
            end else begin
               hs_d = HS_IDLE;
            end
         end
         HS_FULL: begin
            if (lvl_d != FULL_LVL) begin
               hs_d = HS_IDLE;
            end
         end
         default: hs_d = HS_WAIT;
      endcase
   end

   always_comb begin
      pr_d  = pr_q;
      prn_d = prn_q;
      unique case (pr_q)
         P_IDLE: begin
            if (pop) begin
               pr_d  = P_BUSY;
               prn_d = PRN_LOAD;
            end
         end
         P_BUSY: begin
            if (prn_q != '0) begin
               prn_d = prn_q - CW'(1);
            end else begin
               pr_d = P_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_q] <= i_pd;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_q          <= HS_WAIT;
         ack_q         <= '0;
         pr_q          <= P_IDLE;
         prn_q         <= '0;
         wr_q          <= '0;
         rd_q          <= '0;
         lvl_q         <= '0;
         char_q        <= '0;
         o_print_valid <= 1'b0;
         o_print_data  <= '0;
         o_busy        <= 1'b0;
         o_char_count  <= '0;
      end else begin
         hs_q          <= hs_d;
         ack_q         <= ack_d;
         pr_q          <= pr_d;
         prn_q         <= prn_d;
         lvl_q         <= lvl_d;
         o_print_valid <= done;
         o_busy        <= (pr_d == P_BUSY) || (lvl_d != '0);
         if (push) begin
            wr_q <= wr_q + PW'(1);
         end
         if (pop) begin
            rd_q   <= rd_q + PW'(1);
            char_q <= mem[rd_q];
         end
         if (done) begin
            o_print_data <= char_q;
         end
         if (push && (o_char_count != 16'hFFFF)) begin
            o_char_count <= o_char_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/printer_receiver.md
Name: printer_receiver

Overview:
- Printer-side responder for the POC-to-printer parallel handshake (TR/PD from POC, RDY back to POC).
- Accepts bytes from the POC and buffers them in a small FIFO.
- A print engine drains the FIFO at a fixed per-character time and reports each printed byte.
- Sits at the far end of the POC printer port and replaces the free-running printer model in system simulation.

Parameters:
- DATA_W, 8, width of the PD bus and of printed characters.
- FIFO_DEPTH, 4, buffer entries; a power of 2, at least 2.
- ACK_CYCLES, 2, cycles RDY stays low after each capture; at least 1.
- PRINT_CYCLES, 8, cycles to print one character; at least 1.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_tr  input  1  transfer request from the POC; i_pd is valid while high.
- i_pd  input  DATA_W  character from the POC.
- o_rdy  output  1  printer ready to accept a character; registered.
- o_print_valid  output  1  one-cycle pulse when a character finishes printing.
- o_print_data  output  DATA_W  printed character; valid when o_print_valid=1, held otherwise.
- o_busy  output  1  high while the print engine is printing or the FIFO is non-empty.
- o_char_count  output  16  total characters captured since reset; saturates at 0xFFFF.
- o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - o_rdy=0, o_print_valid=0, o_print_data=0, o_busy=0, o_char_count=0, o_fifo_level=0.
  - FIFO pointers cleared; handshake FSM in WAIT with its counter=0; print FSM in P_IDLE.
- Reset mid-operation discards all FIFO contents and any in-progress print; no o_print_valid is emitted for them.
- Handshake FSM states: IDLE, WAIT, FULL.
  - WAIT with counter=0 (post-reset): go to IDLE at the next edge, so o_rdy=1 in the first cycle after reset release.
  - IDLE (o_rdy=1): capture condition is i_tr=1 at a rising edge. On capture: push i_pd, increment o_char_count, go to WAIT, load counter=ACK_CYCLES-1, and o_rdy=0 from the next cycle.
  - WAIT (o_rdy=0): counter decrements each cycle. At counter=0, go to IDLE if the FIFO is not full (after same-cycle push/pop), else go to FULL.
  - FULL (o_rdy=0): go to IDLE in the cycle after a pop makes room.
  - Net effect: RDY is low for exactly ACK_CYCLES cycles after a capture when there is space.
- i_tr is ignored while o_rdy=0. The POC must drop TR after seeing RDY low. TR still high when RDY returns is captured as a new character.
- Capture is level-based; there is no edge detection on i_tr. i_pd is sampled only in the capture cycle.
- A capture never occurs when the FIFO is full, so overflow is impossible by construction.
- Print FSM states: P_IDLE, P_BUSY.
  - P_IDLE with FIFO non-empty: pop the head into the print register, load the print counter with PRINT_CYCLES-1, go to P_BUSY.
  - P_BUSY: counter decrements. At 0: o_print_valid=1 for one cycle, o_print_data=character, return to P_IDLE.
  - The next pop may happen in the same cycle o_print_valid is asserted. Sustained throughput is one character per PRINT_CYCLES+1 cycles.
- Latency from a capture edge into an empty, idle printer to o_print_valid: PRINT_CYCLES+1 cycles (one cycle for the pop, then PRINT_CYCLES).
- Simultaneous push and pop: level unchanged, both take effect, and a push into a full FIFO with a same-cycle pop is not permitted. The FULL exit uses the post-pop level.
- Pointers wrap modulo FIFO_DEPTH. Full means level=FIFO_DEPTH; empty means level=0.
- o_busy = (print FSM in P_BUSY) or (level != 0); registered.
- o_char_count saturates at 0xFFFF, with no wrap.
- Characters are printed strictly in capture order.

Test Plan:
- Reset release with i_tr=0: o_rdy 0 during reset, 1 on the first cycle after release; all other outputs 0.
- Single byte 0x1F with TR held until RDY low (defaults):
  - o_rdy low for exactly 2 cycles.
  - o_print_valid pulses once, 9 cycles after the capture, with o_print_data=0x1F.
  - o_char_count=1.
- Burst of 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x00, with TR re-asserted as soon as RDY returns:
  - FIFO reaches level 4; RDY stays low (FULL) until the first pop.
  - All 6 characters print in order, spaced 9 cycles apart; o_char_count=6.
- TR held high continuously for 40 cycles with i_pd=0xAA:
  - A new capture every ACK_CYCLES+1 cycles while there is space, then throttled by FULL.
  - Capture count equals the print count after drain.
- Async reset asserted mid-print with 3 bytes queued:
  - Outputs return to reset values immediately.
  - No o_print_valid appears after release; o_fifo_level=0.
- PRINT_CYCLES=1, ACK_CYCLES=1, FIFO_DEPTH=2 with back-to-back TR:
  - Simultaneous push/pop keeps the level constant.
  - No lost or duplicated bytes over 20 transfers.
